// File: rtl/vram_dbuf.sv
// vram_dbuf: double-buffered pixel store for a VGA scan-out path.
// The front bank is read at 2-cycle latency from the HCV/VCV timing counters
// with integer upscaling; the back bank takes pixel writes. A requested
// front/back exchange is deferred to the start of vertical blank.
// Optional feature macro: VRAM_DBUF_CLEAR_EN adds a back-bank fill engine
// (clr_req / clr_colour / clr_busy).
module vram_dbuf #(
   parameter int unsigned       H_RES      = 320,
   parameter int unsigned       V_RES      = 240,
   parameter int unsigned       PIX_W      = 12,
   parameter int unsigned       SCALE_LOG2 = 1,
   parameter int unsigned       H_START    = 144,
   parameter int unsigned       V_START    = 35,
   parameter logic [PIX_W-1:0]  BORDER     = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [15:0]                HCV,
   input  logic [15:0]                VCV,
   input  logic                       wr_en,
   input  logic [$clog2(H_RES)-1:0]   wr_x,
   input  logic [$clog2(V_RES)-1:0]   wr_y,
   input  logic [PIX_W-1:0]           wr_data,
   input  logic                       swap_req,
   output logic                       swap_ack,
   output logic [PIX_W-1:0]           rval,
   output logic                       rvalid,
   output logic                       wr_drop
`ifdef VRAM_DBUF_CLEAR_EN
   ,
   input  logic                       clr_req,
   input  logic [PIX_W-1:0]           clr_colour,
   output logic                       clr_busy
`endif
);

   localparam int unsigned DEPTH = H_RES * V_RES;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned H_END = H_START + (H_RES << SCALE_LOG2);
   localparam int unsigned V_END = V_START + (V_RES << SCALE_LOG2);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_SWAP} state_t;

   state_t             state_q, state_d;
   logic               front_q;
   logic               win1_q, sel1_q;
   logic [PIX_W-1:0]   rd0_q, rd1_q;
   logic [PIX_W-1:0]   rval_q;
   logic               rvalid_q;
   logic               wr_drop_q;

   logic [PIX_W-1:0]   mem0 [0:DEPTH-1];
   logic [PIX_W-1:0]   mem1 [0:DEPTH-1];

   logic [31:0]        hcv_w, vcv_w, hcv_off, vcv_off;
   logic               in_win, vblank_start;
   logic [AW-1:0]      rd_addr, wr_addr, w_addr;
   logic [PIX_W-1:0]   w_data;
   logic               wr_ok, w_en, busy;
   logic               we0, we1, re0, re1;

   // Display-side address generation and window decode
   always_comb begin
      hcv_w        = {16'd0, HCV};
      vcv_w        = {16'd0, VCV};
      hcv_off      = hcv_w - H_START;
      vcv_off      = vcv_w - V_START;
      in_win       = (hcv_w >= H_START) && (hcv_w < H_END) &&
                     (vcv_w >= V_START) && (vcv_w < V_END);
      rd_addr      = AW'(((vcv_off >> SCALE_LOG2) * H_RES) + (hcv_off >> SCALE_LOG2));
      vblank_start = (vcv_w == V_END) && (HCV == 16'd0);
   end

   // Write-side address and acceptance
   always_comb begin
      wr_addr = AW'(wr_y) * AW'(H_RES) + AW'(wr_x);
      wr_ok   = wr_en && (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES) && !busy;
   end

`ifdef VRAM_DBUF_CLEAR_EN
   logic               clr_busy_q;
   logic [AW-1:0]      clr_addr_q;
   logic [PIX_W-1:0]   clr_col_q;

   assign busy     = clr_busy_q;
   assign clr_busy = clr_busy_q;

   // Clear engine: sweep the back bank one word per cycle; requests while busy are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_busy_q <= 1'b0;
         clr_addr_q <= '0;
         clr_col_q  <= '0;
      end else if (clr_busy_q) begin
         if (clr_addr_q == AW'(DEPTH - 1)) clr_busy_q <= 1'b0;
         clr_addr_q <= clr_addr_q + 1'b1;
      end else if (clr_req) begin
         clr_busy_q <= 1'b1;
         clr_addr_q <= '0;
         clr_col_q  <= clr_colour;
      end
   end

   // Back-bank write port: clear engine owns it while busy
   always_comb begin
      w_en   = wr_ok | clr_busy_q;
      w_addr = clr_busy_q ? clr_addr_q : wr_addr;
      w_data = clr_busy_q ? clr_col_q  : wr_data;
   end
`else
   assign busy = 1'b0;

   // Back-bank write port: external writes only
   always_comb begin
      w_en   = wr_ok;
      w_addr = wr_addr;
      w_data = wr_data;
   end
`endif

   // Bank enables: back bank is the one not selected as front
   always_comb begin
      we0 = w_en & front_q;
      we1 = w_en & ~front_q;
      re0 = in_win & ~front_q;
      re1 = in_win & front_q;
   end

   // Bank 0 storage (no reset, block-RAM style)
   always_ff @(posedge clk) begin
      if (we0) mem0[w_addr] <= w_data;
      if (re0) rd0_q <= mem0[rd_addr];
   end

   // Bank 1 storage (no reset, block-RAM style)
   always_ff @(posedge clk) begin
      if (we1) mem1[w_addr] <= w_data;
      if (re1) rd1_q <= mem1[rd_addr];
   end

   // Read pipeline: bank select is captured with the address so a swap cannot tear a pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win1_q   <= 1'b0;
         sel1_q   <= 1'b0;
         rval_q   <= BORDER;
         rvalid_q <= 1'b0;
      end else begin
         win1_q   <= in_win;
         sel1_q   <= front_q;
         rval_q   <= win1_q ? (sel1_q ? rd1_q : rd0_q) : BORDER;
         rvalid_q <= win1_q;
      end
   end

   // Drop flag for rejected writes, one cycle after the attempt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_drop_q <= 1'b0;
      else        wr_drop_q <= wr_en & ~wr_ok;
   end

   // Swap FSM state register and front-bank select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         front_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_SWAP) front_q <= ~front_q;
      end
   end

   // Swap FSM next state and ack
   always_comb begin
      state_d  = state_q;
      swap_ack = 1'b0;
      case (state_q)
         S_IDLE: if (swap_req) state_d = S_PEND;
         S_PEND: if (vblank_start && !busy) state_d = S_SWAP;
         S_SWAP: begin
            swap_ack = 1'b1;
            state_d  = swap_req ? S_PEND : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rval    = rval_q;
   assign rvalid  = rvalid_q;
   assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_vram_dbuf.sv
// Directed self-checking bench for vram_dbuf (default parameters).
// Clear-engine checks are built only when VRAM_DBUF_CLEAR_EN is defined.
module tb_vram_dbuf;

   logic        clk;
   logic        rst_n;
   logic [15:0] HCV, VCV;
   logic        wr_en;
   logic [8:0]  wr_x;
   logic [7:0]  wr_y;
   logic [11:0] wr_data;
   logic        swap_req;
   logic        swap_ack;
   logic [11:0] rval;
   logic        rvalid;
   logic        wr_drop;
`ifdef VRAM_DBUF_CLEAR_EN
   logic        clr_req;
   logic [11:0] clr_colour;
   logic        clr_busy;
`endif

   int total = 0;
   int bad   = 0;
   int acks;

   vram_dbuf #(
      .H_RES(320), .V_RES(240), .PIX_W(12), .SCALE_LOG2(1),
      .H_START(144), .V_START(35), .BORDER(12'h000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .HCV(HCV), .VCV(VCV),
      .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .rval(rval), .rvalid(rvalid), .wr_drop(wr_drop)
`ifdef VRAM_DBUF_CLEAR_EN
      , .clr_req(clr_req), .clr_colour(clr_colour), .clr_busy(clr_busy)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [8:0] x, input logic [7:0] y, input logic [11:0] d, input logic exp_drop);
      wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
      tick;
      wr_en = 1'b0;
      check("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
   endtask

   task automatic rd(input string tag, input logic [15:0] h, input logic [15:0] v,
                     input logic [11:0] exp_val, input logic exp_vld);
      HCV = h; VCV = v;
      tick;
      tick;
      check({tag, "_rval"},   {20'd0, rval},   {20'd0, exp_val});
      check({tag, "_rvalid"}, {31'd0, rvalid}, {31'd0, exp_vld});
      HCV = 16'd0; VCV = 16'd0;
   endtask

   task automatic blank_ack(input string tag, input logic exp_ack);
      HCV = 16'd0; VCV = 16'd515;
      tick;
      check(tag, {31'd0, swap_ack}, {31'd0, exp_ack});
      VCV = 16'd0;
   endtask

`ifdef VRAM_DBUF_CLEAR_EN
   int cnt;
   task automatic tick_busy;
      tick;
      if (clr_busy) cnt++;
   endtask
`endif

   initial begin
      rst_n = 1'b0; HCV = '0; VCV = '0;
      wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; swap_req = 1'b0;
`ifdef VRAM_DBUF_CLEAR_EN
      clr_req = 1'b0; clr_colour = '0;
`endif
      tick; tick;
      check("rst_rval",   {20'd0, rval},     32'h000);
      check("rst_rvalid", {31'd0, rvalid},   32'd0);
      check("rst_ack",    {31'd0, swap_ack}, 32'd0);
      check("rst_drop",   {31'd0, wr_drop},  32'd0);
      rst_n = 1'b1;
      tick;

      // back-bank writes, including corner and out-of-range
      wr(9'd5,   8'd3,   12'hABC, 1'b0);
      wr(9'd319, 8'd239, 12'h123, 1'b0);
      wr(9'd0,   8'd1,   12'h111, 1'b0);
      wr(9'd320, 8'd0,   12'h777, 1'b1);
      wr(9'd0,   8'd240, 12'h777, 1'b1);
      tick;
      check("drop_clears", {31'd0, wr_drop}, 32'd0);

      // three requests in one frame, one ack at blank start
      for (int i = 0; i < 3; i++) begin
         swap_req = 1'b1; tick;
         swap_req = 1'b0; tick;
         check("pend_noack", {31'd0, swap_ack}, 32'd0);
      end
      HCV = 16'd0; VCV = 16'd515;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (swap_ack) acks++;
      end
      check("one_ack", acks, 32'd1);
      VCV = 16'd0;
      tick; tick;

      // latency boundary then pixel (5,3)
      HCV = 16'd154; VCV = 16'd41;
      tick;
      check("lat1_rvalid", {31'd0, rvalid}, 32'd0);
      tick;
      check("px53_rval",   {20'd0, rval},   32'hABC);
      check("px53_rvalid", {31'd0, rvalid}, 32'd1);
      HCV = 16'd0; VCV = 16'd0;
      rd("px_last",  16'd783, 16'd514, 12'h123, 1'b1);
      rd("px01",     16'd144, 16'd37,  12'h111, 1'b1);
      rd("border_a", 16'd100, 16'd200, 12'h000, 1'b0);
      rd("border_h", 16'd784, 16'd100, 12'h000, 1'b0);
      rd("border_v", 16'd144, 16'd34,  12'h000, 1'b0);

      // write and request during the SWAP cycle
      swap_req = 1'b1; tick; swap_req = 1'b0;
      blank_ack("swap2_ack", 1'b1);
      wr_en = 1'b1; wr_x = 9'd7; wr_y = 8'd7; wr_data = 12'h5A5; swap_req = 1'b1;
      tick;
      wr_en = 1'b0; swap_req = 1'b0;
      check("swap2_done", {31'd0, swap_ack}, 32'd0);
      rd("px77", 16'd158, 16'd49, 12'h5A5, 1'b1);
      blank_ack("swap3_ack", 1'b1);
      tick;
      rd("px53_back", 16'd154, 16'd41, 12'hABC, 1'b1);

      // reset while pending
      swap_req = 1'b1; tick; swap_req = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstp_ack", {31'd0, swap_ack}, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      blank_ack("rstp_noack1", 1'b0);
      blank_ack("rstp_noack2", 1'b0);
      rd("rstp_front0", 16'd158, 16'd49, 12'h5A5, 1'b1);

`ifdef VRAM_DBUF_CLEAR_EN
      cnt = 0;
      clr_colour = 12'hF00;
      clr_req = 1'b1; tick_busy; clr_req = 1'b0;
      check("clr_busy", {31'd0, clr_busy}, 32'd1);
      wr_en = 1'b1; wr_x = 9'd1; wr_y = 8'd1; wr_data = 12'h0AA;
      tick_busy;
      wr_en = 1'b0;
      check("clr_wr_drop", {31'd0, wr_drop}, 32'd1);
      swap_req = 1'b1; tick_busy; swap_req = 1'b0;
      clr_req = 1'b1; tick_busy; clr_req = 1'b0;
      HCV = 16'd0; VCV = 16'd515;
      tick_busy;
      check("clr_swap_wait", {31'd0, swap_ack}, 32'd0);
      VCV = 16'd0;
      while (clr_busy && cnt < 80000) tick_busy;
      check("clr_cycles", cnt, 32'd76800);
      blank_ack("clr_swap_ack", 1'b1);
      tick;
      rd("clr_px00", 16'd144, 16'd35,  12'hF00, 1'b1);
      rd("clr_px11", 16'd146, 16'd37,  12'hF00, 1'b1);
      rd("clr_px53", 16'd154, 16'd41,  12'hF00, 1'b1);
      rd("clr_pxc",  16'd464, 16'd275, 12'hF00, 1'b1);
      rd("clr_pxl",  16'd782, 16'd513, 12'hF00, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
